// File: rtl/alu_cmd_sequencer.sv
// Command front end for the N-bit arithmetic unit: accepts register-to-register
// commands, drives the unit for one EXEC cycle, writes the register file and returns a response.
module alu_cmd_sequencer #(
    parameter int N    = 4,
    parameter int REGS = 4,
    localparam int RW  = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_ra,
    input  logic [RW-1:0] cmd_rb,
    input  logic          cmd_imm_en,
    input  logic [N-1:0]  cmd_imm,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_s,
    input  logic [N-1:0]  alu_out,
    input  logic          alu_cout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic [3:0]    rsp_flags
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // cmd_ready is high only in IDLE; rsp_valid is high only in RESP, with data/flags frozen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b111;

    state_t        state_q;
    logic [2:0]    op_q;
    logic [RW-1:0] rd_q;
    logic [N-1:0]  imm_q;
    logic [N-1:0]  regs_q [REGS];
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [N-1:0]  rsp_data_q;
    logic [3:0]    rsp_flags_q;
    logic [N-1:0]  alu_a_q;
    logic [N-1:0]  alu_b_q;
    logic [2:0]    alu_s_q;

    logic          cmd_is_alu;
    logic [N-1:0]  operand_b_d;
    logic          op_illegal;
    logic [N-1:0]  result_d;
    logic [3:0]    flags_d;

    always_comb begin
        cmd_is_alu  = (cmd_op <= 3'd4);
        operand_b_d = cmd_imm_en ? cmd_imm : regs_q[cmd_rb];
        op_illegal  = (op_q == 3'b101) || (op_q == 3'b110);
        result_d    = '0;
        if (op_q <= 3'd4) begin
            result_d = alu_out;
        end else if (op_q == OP_LOAD) begin
            result_d = imm_q;
        end
        // Flags are {E, C, Nf, Z}; an illegal op reports only E.
        if (op_illegal) begin
            flags_d = 4'b1000;
        end else begin
            flags_d = {1'b0, (op_q == OP_ADD) && alu_cout, result_d[N-1], result_d == '0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        rd_q        <= cmd_rd;
                        imm_q       <= cmd_imm;
                        cmd_ready_q <= 1'b0;
                        // Operands are read now; no write can land before EXEC ends.
                        if (cmd_is_alu) begin
                            alu_a_q <= regs_q[cmd_ra];
                            alu_b_q <= operand_b_d;
                            alu_s_q <= cmd_op;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= result_d;
                    rsp_flags_q <= flags_d;
                    rsp_valid_q <= 1'b1;
                    if (!op_illegal) begin
                        regs_q[rd_q] <= result_d;
                    end
                    alu_a_q <= '0;
                    alu_b_q <= '0;
                    alu_s_q <= '0;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural arithmetic unit, transaction-level reference
// model checked every cycle, plus directed scenarios with hand-computed results.
module tb_alu_cmd_sequencer;

    localparam int N    = 4;
    localparam int REGS = 4;
    localparam int RW   = 2;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [RW-1:0] cmd_rd;
    logic [RW-1:0] cmd_ra;
    logic [RW-1:0] cmd_rb;
    logic          cmd_imm_en;
    logic [N-1:0]  cmd_imm;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [2:0]    alu_s;
    logic [N-1:0]  alu_out;
    logic          alu_cout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic [3:0]    rsp_flags;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.N(N), .REGS(REGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic unit: SUB drives a borrow on cout so a leak into C is visible.
    function automatic logic [N:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] s);
        logic [N-1:0] r;
        logic         c;
        int           k;
        c = 1'b0;
        r = '0;
        case (s)
            3'd0: {c, r} = {1'b0, a} + {1'b0, b};
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = $signed(a) >>> b;
            3'd3: r = a << b;
            3'd4: begin k = int'(b) % N; r = (a << k) | (a >> (N - k)); end
            default: r = '0;
        endcase
        return {c, r};
    endfunction

    assign {alu_cout, alu_out} = alu_f(alu_a, alu_b, alu_s);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 waiting for a command, 1 unit being driven, 2 response offered.
    int           m_phase = 0;
    logic [N-1:0] m_regs [REGS];
    logic [2:0]   m_op;
    logic [RW-1:0] m_rd;
    logic [N-1:0] m_imm;
    logic [N-1:0] m_alu_a = '0;
    logic [N-1:0] m_alu_b = '0;
    logic [2:0]   m_alu_s = '0;
    logic [N-1:0] m_rsp_d = '0;
    logic [3:0]   m_rsp_f = '0;
    logic [N-1:0] m_r;
    logic         m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            for (int i = 0; i < REGS; i++) m_regs[i] = '0;
            m_alu_a = '0; m_alu_b = '0; m_alu_s = '0;
            m_rsp_d = '0; m_rsp_f = '0;
        end else if (m_phase == 0) begin
            if (cmd_valid) begin
                m_op  = cmd_op;
                m_rd  = cmd_rd;
                m_imm = cmd_imm;
                if (cmd_op <= 3'd4) begin
                    m_alu_a = m_regs[cmd_ra];
                    m_alu_b = cmd_imm_en ? cmd_imm : m_regs[cmd_rb];
                    m_alu_s = cmd_op;
                end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_op <= 3'd4) begin
                {m_c, m_r} = alu_f(m_alu_a, m_alu_b, m_op);
                m_rsp_d = m_r;
                m_rsp_f = {1'b0, (m_op == 3'd0) && m_c, m_r[N-1], m_r == '0};
                m_regs[m_rd] = m_r;
            end else if (m_op == 3'd7) begin
                m_rsp_d = m_imm;
                m_rsp_f = {2'b00, m_imm[N-1], m_imm == '0};
                m_regs[m_rd] = m_imm;
            end else begin
                m_rsp_d = '0;
                m_rsp_f = 4'b1000;
            end
            m_alu_a = '0; m_alu_b = '0; m_alu_s = '0;
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
            chk("rst_alu_a", 32'(alu_a), 32'd0);
            chk("rst_alu_b", 32'(alu_b), 32'd0);
            chk("rst_alu_s", 32'(alu_s), 32'd0);
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("alu_a", 32'(alu_a), 32'(m_alu_a));
            chk("alu_b", 32'(alu_b), 32'(m_alu_b));
            chk("alu_s", 32'(alu_s), 32'(m_alu_s));
            if (m_phase == 2) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
                chk("rsp_flags", 32'(rsp_flags), 32'(m_rsp_f));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [2:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] ra,
                           input logic [RW-1:0] rb, input logic ie, input logic [N-1:0] imm,
                           input int hold, input bit keep,
                           output logic [N-1:0] d, output logic [3:0] f, output logic [2:0] es);
        int t;
        int lat;
        logic [N-1:0] d0;
        logic [3:0]   f0;
        d = '0; f = '0; es = '0;
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm_en = ie; cmd_imm = imm;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout cmd_ready=0 expected=1 t=%0t", $time);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = keep;
        cmd_op = 3'($urandom_range(0, 7)); cmd_rd = 2'($urandom_range(0, 3));
        cmd_ra = 2'($urandom_range(0, 3)); cmd_rb = 2'($urandom_range(0, 3));
        cmd_imm_en = 1'($urandom_range(0, 1)); cmd_imm = 4'($urandom_range(0, 15));
        @(negedge clk);
        es  = alu_s;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency_edges", 32'(lat), 32'd2);
        if (!rsp_valid) begin
            cmd_valid = 1'b0;
            return;
        end
        d0 = rsp_data;
        f0 = rsp_flags;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_data", 32'(rsp_data), 32'(d0));
            chk("hold_flags", 32'(rsp_flags), 32'(f0));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        d = rsp_data;
        f = rsp_flags;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [N-1:0] d;
        logic [3:0]   f;
        logic [2:0]   es;
        cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_ra = 0; cmd_rb = 0;
        cmd_imm_en = 0; cmd_imm = 0; rsp_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 4'd5, 0, 1'b0, d, f, es);
        chk("load_r0_5", 32'(d), 32'd5);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 4'd3, 0, 1'b0, d, f, es);
        chk("load_alu_s_idle", 32'(es), 32'd0);
        run_cmd(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, 0, 1'b0, d, f, es);
        chk("add_5_3_data", 32'(d), 32'd8);
        chk("add_5_3_flags", 32'(f), 32'b0010);

        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 4'd9, 0, 1'b0, d, f, es);
        run_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd0, 1, 1'b0, d, f, es);
        chk("add_9_9_data", 32'(d), 32'd2);
        chk("add_9_9_flags", 32'(f), 32'b0100);
        run_cmd(3'd1, 2'd2, 2'd1, 2'd0, 1'b1, 4'd2, 0, 1'b0, d, f, es);
        chk("sub_2_2_data", 32'(d), 32'd0);
        chk("sub_2_2_flags", 32'(f), 32'b0001);

        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 4'b1000, 0, 1'b0, d, f, es);
        run_cmd(3'd2, 2'd1, 2'd0, 2'd0, 1'b1, 4'd1, 0, 1'b0, d, f, es);
        chk("asr_data", 32'(d), 32'b1100);
        chk("asr_flags", 32'(f), 32'b0010);
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 4'b0011, 0, 1'b0, d, f, es);
        run_cmd(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 4'd2, 0, 1'b0, d, f, es);
        chk("shl_data", 32'(d), 32'b1100);
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 4'b1001, 0, 1'b0, d, f, es);
        run_cmd(3'd4, 2'd1, 2'd0, 2'd0, 1'b1, 4'd1, 0, 1'b0, d, f, es);
        chk("rot_alu_s_exec", 32'(es), 32'b100);
        chk("rot_data", 32'(d), 32'b0011);

        run_cmd(3'd7, 2'd3, 2'd0, 2'd0, 1'b0, 4'd7, 0, 1'b0, d, f, es);
        run_cmd(3'd5, 2'd3, 2'd3, 2'd3, 1'b0, 4'd9, 0, 1'b0, d, f, es);
        chk("illegal_data", 32'(d), 32'd0);
        chk("illegal_flags", 32'(f), 32'b1000);
        chk("illegal_alu_s", 32'(es), 32'd0);
        run_cmd(3'd0, 2'd2, 2'd3, 2'd0, 1'b1, 4'd0, 0, 1'b0, d, f, es);
        chk("r3_kept_data", 32'(d), 32'd7);
        chk("r3_kept_flags", 32'(f), 32'b0000);

        run_cmd(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 4'd4, 5, 1'b1, d, f, es);
        chk("backpressure_data", 32'(d), 32'd4);
        @(negedge clk);
        chk("no_second_accept", 32'(cmd_ready), 32'd1);

        // Reset landing in EXEC of ADD r1 = r0 + r1.
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 4'd6, 0, 1'b0, d, f, es);
        @(negedge clk);
        cmd_op = 3'd0; cmd_rd = 2'd1; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_imm_en = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_cmd(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 4'd0, 0, 1'b0, d, f, es);
        chk("r1_after_abort", 32'(d), 32'd0);
        chk("r1_after_abort_flags", 32'(f), 32'b0001);

        for (int i = 0; i < 60; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, f, es);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
